action_arbiter: RTL and testbench
=================================

# action_arbiter

Round-robin arbiter that shares one action engine among NUM_REQ match-table result streams. Each requester presents a packet beat with its resolved action ID and action data. The arbiter grants one requester per transfer and registers the winning beat into a single output stage that drives the engine's packet/action inputs. It records the source port of every beat the engine accepts in a tag FIFO, so each engine output beat is labelled with the requester it came from.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- DATA_WIDTH, 512: packet beat width.
- ACTION_DATA_WIDTH, 128: action data width.
- TAG_DEPTH, 4: tag FIFO entries, power of two, ≥2.
- Derived: IDX_W = $clog2(NUM_REQ).

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_packet  in  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies slice i.
- req_action_id  in  NUM_REQ*3  packed action IDs.
- req_action_data  in  NUM_REQ*ACTION_DATA_WIDTH  packed action data.
- eng_packet  out  DATA_WIDTH  drives engine packet_in.
- eng_action_id  out  3  drives engine action_id.
- eng_action_data  out  ACTION_DATA_WIDTH  drives engine action_data.
- eng_valid  out  1  drives both engine packet_valid and action_valid.
- eng_ready  in  1  engine packet_ready.
- eng_out_valid  in  1  engine packet_out_valid (monitored only).
- eng_out_ready  in  1  downstream packet_out_ready (monitored only).
- out_src_port  out  IDX_W  source requester of the current engine output beat.
- out_src_valid  out  1  out_src_port is valid; equals eng_out_valid && tag FIFO not empty.
- tag_error  out  1  sticky flag: an engine output beat was seen with the tag FIFO empty.

## Operation
- Output stage:
  - One register holds eng_packet, eng_action_id, eng_action_data and stage_valid.
  - eng_valid = stage_valid && !tag_full.
  - accept_eng = eng_valid && eng_ready.
- Load condition: load_ok = !stage_valid || accept_eng.
- Arbitration, evaluated combinationally each cycle:
  - Search req_valid starting at (last_grant+1) mod NUM_REQ, wrapping; the first set bit wins, index g.
  - If load_ok and a winner exists: req_ready[g]=1, the stage loads slice g, stage_valid←1, last_grant←g.
  - Otherwise req_ready=0, and stage_valid←0 if accept_eng occurred.
- A requester sees req_ready only while its req_valid is high. Requesters must hold valid and data until they are accepted.
- Tag FIFO:
  - Push last_grant's registered value, i.e. the source of the current stage beat, on accept_eng.
  - Pop on eng_out_valid && eng_out_ready.
  - Push and pop in the same cycle: occupancy is unchanged and the push is allowed even when the FIFO is full.
  - tag_full stalls eng_valid only. It does not stall arbitration unless the stage is occupied.
- The engine emits exactly one output beat per accepted input, including DROP and unknown-ID beats. Tag order therefore equals output order.
- tag_error: set when eng_out_valid && eng_out_ready and the FIFO is empty. No pop occurs in that case. Cleared only by reset.

## Timing
- Requester accept to eng_valid: 1 cycle.
- Throughput: 1 beat/cycle when eng_ready stays high and tag FIFO occupancy is below TAG_DEPTH.
- Engine accept to out_src_valid: 1 cycle, matching the engine's single register stage.
- Reset values:
  - eng_valid 0; all eng_* data 0.
  - req_ready 0.
  - last_grant = NUM_REQ-1, so port 0 wins first.
  - Tag FIFO empty; out_src_valid 0; out_src_port 0; tag_error 0.
- Reset mid-transfer discards the staged beat and all tags. Requesters re-present their beats after reset.
- With only one requester active, it is granted every cycle; fairness is irrelevant.
- If eng_ready is low while the stage is occupied, the stage holds and all req_ready are 0.

## Structure
- action_pkg holds the action ID constants (FORWARD=0, DROP=1, NOACTION=2, ENCAP=3, DECAP=4, HASH_SELECT=5) and ACTION_ID_W=3, shared with the engine.
- Sub-module action_tag_fifo: synchronous FIFO of IDX_W-bit entries with push, pop, full, empty and dout, where dout is first-word fall-through.
- Round-robin priority search stays inline in action_arbiter.

## Test plan
- All 4 requesters held valid, eng_ready=1 → grants in order 0,1,2,3,0,…; eng_valid continuous; out_src_port follows the same sequence one cycle behind the engine accept.
- Only req 2 valid, eng_ready=1 → req_ready[2] high every cycle; 8 beats produce 8 tags, all equal to 2.
- Stage loaded from req 1, eng_ready=0 for 5 cycles → eng_packet stable; all req_ready 0; after release, next grant goes to 2 if valid.
- eng_out_ready=0 with TAG_DEPTH=4 → after 4 engine accepts eng_valid drops while stage_valid stays 1; one pop re-enables eng_valid on the next cycle.
- Inject eng_out_valid=1, eng_out_ready=1 after reset with no beats issued → tag_error=1 and stays 1; out_src_valid stays 0.
- Assert aresetn low with 3 tags queued → all outputs return to reset values; the first grant after reset goes to req 0.

Source files
------------

// File: rtl/action_pkg.sv
// Action-ID constants shared by the action engine and its input arbiter.
package action_pkg;

  localparam int unsigned ACTION_ID_W = 3;

  typedef enum logic [ACTION_ID_W-1:0] {
    FORWARD     = 3'd0,
    DROP        = 3'd1,
    NOACTION    = 3'd2,
    ENCAP       = 3'd3,
    DECAP       = 3'd4,
    HASH_SELECT = 3'd5
  } action_id_e;

endpackage

// File: rtl/action_tag_fifo.sv
// Source-port tag FIFO with first-word fall-through read data.
module action_tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Caller guarantees pop only when non-empty and push when full only alongside a pop.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/action_arbiter.sv
// Round-robin arbiter feeding one action engine from NUM_REQ match-table streams,
// tagging every engine output beat with the requester it came from.
module action_arbiter
  import action_pkg::*;
#(
  parameter int unsigned NUM_REQ           = 4,
  parameter int unsigned DATA_WIDTH        = 512,
  parameter int unsigned ACTION_DATA_WIDTH = 128,
  parameter int unsigned TAG_DEPTH         = 4,
  localparam int unsigned IDX_W            = $clog2(NUM_REQ)
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]          req_packet,
  input  logic [NUM_REQ*ACTION_ID_W-1:0]         req_action_id,
  input  logic [NUM_REQ*ACTION_DATA_WIDTH-1:0]   req_action_data,
  output logic [DATA_WIDTH-1:0]                  eng_packet,
  output logic [ACTION_ID_W-1:0]                 eng_action_id,
  output logic [ACTION_DATA_WIDTH-1:0]           eng_action_data,
  output logic                                   eng_valid,
  input  logic                                   eng_ready,
  input  logic                                   eng_out_valid,
  input  logic                                   eng_out_ready,
  output logic [IDX_W-1:0]                       out_src_port,
  output logic                                   out_src_valid,
  output logic                                   tag_error
);

  logic                         r_stage_valid;
  logic [DATA_WIDTH-1:0]        r_packet;
  logic [ACTION_ID_W-1:0]       r_action_id;
  logic [ACTION_DATA_WIDTH-1:0] r_action_data;
  logic [IDX_W-1:0]             r_last_grant;
  logic                         r_tag_error;

  logic             w_tag_full;
  logic             w_tag_empty;
  logic             w_eng_valid;
  logic             w_accept;
  logic             w_load_ok;
  logic             w_load;
  logic             w_out_hs;
  logic             w_pop;
  logic             w_found;
  logic [IDX_W-1:0] w_grant;
  int unsigned      w_idx;

  assign w_eng_valid = r_stage_valid && !w_tag_full;
  assign w_accept    = w_eng_valid && eng_ready;
  assign w_load_ok   = !r_stage_valid || w_accept;
  assign w_out_hs    = eng_out_valid && eng_out_ready;
  assign w_pop       = w_out_hs && !w_tag_empty;

  // Priority search starting one past the last grant, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = (32'(r_last_grant) + k) % NUM_REQ;
      if (!w_found && req_valid[IDX_W'(w_idx)]) begin
        w_found = 1'b1;
        w_grant = IDX_W'(w_idx);
      end
    end
  end

  // aresetn gate keeps req_ready low while reset is held.
  assign w_load = w_load_ok && w_found && aresetn;

  always_comb begin
    req_ready = '0;
    if (w_load) req_ready[w_grant] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_stage_valid <= 1'b0;
      r_packet      <= '0;
      r_action_id   <= '0;
      r_action_data <= '0;
      r_last_grant  <= IDX_W'(NUM_REQ - 1);
    end else if (w_load) begin
      r_stage_valid <= 1'b1;
      r_packet      <= req_packet[32'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
      r_action_id   <= req_action_id[32'(w_grant)*ACTION_ID_W +: ACTION_ID_W];
      r_action_data <= req_action_data[32'(w_grant)*ACTION_DATA_WIDTH +: ACTION_DATA_WIDTH];
      r_last_grant  <= w_grant;
    end else if (w_accept) begin
      r_stage_valid <= 1'b0;
    end
  end

  // Engine output seen with no outstanding tag: sticky until reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_tag_error <= 1'b0;
    else if (w_out_hs && w_tag_empty) r_tag_error <= 1'b1;
  end

  action_tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (w_accept),
    .pop     (w_pop),
    .din     (r_last_grant),
    .dout    (out_src_port),
    .full    (w_tag_full),
    .empty   (w_tag_empty)
  );

  assign eng_valid       = w_eng_valid;
  assign eng_packet      = r_packet;
  assign eng_action_id   = r_action_id;
  assign eng_action_data = r_action_data;
  assign out_src_valid   = eng_out_valid && !w_tag_empty;
  assign tag_error       = r_tag_error;

endmodule

// File: tb/tb_action_arbiter.sv
// Randomized scoreboard bench for action_arbiter with a queue-based reference model.
module tb_action_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned DW  = 512;
  localparam int unsigned ADW = 128;
  localparam int unsigned TD  = 4;
  localparam int unsigned IW  = 2;

  logic              aclk, aresetn;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*DW-1:0]  req_packet;
  logic [NR*3-1:0]   req_action_id;
  logic [NR*ADW-1:0] req_action_data;
  logic [DW-1:0]     eng_packet;
  logic [2:0]        eng_action_id;
  logic [ADW-1:0]    eng_action_data;
  logic              eng_valid, eng_ready, eng_out_valid, eng_out_ready;
  logic [IW-1:0]     out_src_port;
  logic              out_src_valid, tag_error;

  action_arbiter #(
    .NUM_REQ (NR), .DATA_WIDTH (DW), .ACTION_DATA_WIDTH (ADW), .TAG_DEPTH (TD)
  ) dut (
    .aclk (aclk), .aresetn (aresetn),
    .req_valid (req_valid), .req_ready (req_ready), .req_packet (req_packet),
    .req_action_id (req_action_id), .req_action_data (req_action_data),
    .eng_packet (eng_packet), .eng_action_id (eng_action_id),
    .eng_action_data (eng_action_data), .eng_valid (eng_valid), .eng_ready (eng_ready),
    .eng_out_valid (eng_out_valid), .eng_out_ready (eng_out_ready),
    .out_src_port (out_src_port), .out_src_valid (out_src_valid), .tag_error (tag_error)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0]  pkt;
    logic [2:0]     id;
    logic [ADW-1:0] ad;
    int             src;
  } beat_t;

  beat_t exp_eng[$];   // beat expected in the output stage
  int    exp_tag[$];   // sources of beats the engine has taken, in order
  bit    m_tag_err;
  int    m_last;
  int    checks, failures;

  int            eng_cnt;
  bit            force_err;
  int unsigned   new_pct, er_pct, or_pct;
  logic [NR-1:0] mask;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NR-1:0] v);
    for (int k = 1; k <= int'(NR); k++) begin
      int idx;
      idx = (last + k) % int'(NR);
      if (v[IW'(idx)]) return idx;
    end
    return -1;
  endfunction

  // Monitor: compare DUT against the model, then advance the model one cycle.
  bit            mm_ev, mm_acc, mm_load;
  int            mm_w;
  logic [NR-1:0] mm_rdy;
  beat_t         mm_b;
  always @(negedge aclk) begin
    if (!aresetn) begin
      chk("rst_req_ready", DW'(req_ready), '0);
      chk("rst_eng_valid", DW'(eng_valid), '0);
      chk("rst_eng_packet", eng_packet, '0);
      chk("rst_out_src_valid", DW'(out_src_valid), '0);
      chk("rst_out_src_port", DW'(out_src_port), '0);
      chk("rst_tag_error", DW'(tag_error), '0);
      exp_eng.delete();
      exp_tag.delete();
      m_tag_err = 1'b0;
      m_last    = int'(NR) - 1;
    end else begin
      mm_ev   = (exp_eng.size() != 0) && (exp_tag.size() < int'(TD));
      mm_acc  = mm_ev && eng_ready;
      mm_load = ((exp_eng.size() == 0) || mm_acc) && (req_valid != '0);
      mm_w    = rr_pick(m_last, req_valid);
      mm_rdy  = '0;
      if (mm_load) mm_rdy[IW'(mm_w)] = 1'b1;

      chk("eng_valid", DW'(eng_valid), DW'(mm_ev));
      if (mm_ev) begin
        chk("eng_packet", eng_packet, exp_eng[0].pkt);
        chk("eng_action_id", DW'(eng_action_id), DW'(exp_eng[0].id));
        chk("eng_action_data", DW'(eng_action_data), DW'(exp_eng[0].ad));
      end
      chk("req_ready", DW'(req_ready), DW'(mm_rdy));
      chk("out_src_valid", DW'(out_src_valid), DW'(eng_out_valid && exp_tag.size() != 0));
      if (eng_out_valid && exp_tag.size() != 0)
        chk("out_src_port", DW'(out_src_port), DW'(exp_tag[0]));
      chk("tag_error", DW'(tag_error), DW'(m_tag_err));

      if (eng_out_valid && eng_out_ready) begin
        if (exp_tag.size() != 0) void'(exp_tag.pop_front());
        else m_tag_err = 1'b1;
      end
      if (mm_acc) begin
        mm_b = exp_eng.pop_front();
        exp_tag.push_back(mm_b.src);
      end
      if (mm_load) begin
        mm_b.pkt = req_packet[mm_w*DW +: DW];
        mm_b.id  = req_action_id[mm_w*3 +: 3];
        mm_b.ad  = req_action_data[mm_w*ADW +: ADW];
        mm_b.src = mm_w;
        exp_eng.push_back(mm_b);
        m_last = mm_w;
      end
    end
  end

  task automatic new_beat(input int i);
    for (int w = 0; w < int'(DW / 32); w++) req_packet[i*DW + w*32 +: 32] = $urandom();
    for (int w = 0; w < int'(ADW / 32); w++) req_action_data[i*ADW + w*32 +: 32] = $urandom();
    req_action_id[i*3 +: 3] = 3'($urandom_range(7));
    req_valid[i] = 1'b1;
  endtask

  task automatic set_phase(input logic [NR-1:0] m, input int unsigned np,
                           input int unsigned ep, input int unsigned op);
    mask = m; new_pct = np; er_pct = ep; or_pct = op;
  endtask

  // Requesters hold each beat until accepted; engine emits one beat per accepted input a cycle later.
  task automatic run_cycles(input int n);
    logic [NR-1:0] hs;
    bit acc, pop;
    repeat (n) begin
      @(negedge aclk);
      hs  = req_valid & req_ready;
      acc = eng_valid && eng_ready;
      pop = eng_out_valid && eng_out_ready;
      @(posedge aclk);
      #1;
      if (pop && eng_cnt > 0) eng_cnt--;
      if (acc) eng_cnt++;
      eng_out_valid = (eng_cnt > 0) || force_err;
      for (int i = 0; i < int'(NR); i++) begin
        if (hs[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && mask[i] && $urandom_range(99) < new_pct) new_beat(i);
      end
      eng_ready     = ($urandom_range(99) < er_pct);
      eng_out_ready = ($urandom_range(99) < or_pct);
    end
  endtask

  task automatic do_reset();
    aresetn       = 1'b0;
    eng_cnt       = 0;
    eng_out_valid = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0;
    m_tag_err = 1'b0; m_last = int'(NR) - 1;
    aresetn = 1'b0;
    req_valid = '0; req_packet = '0; req_action_id = '0; req_action_data = '0;
    eng_ready = 1'b0; eng_out_valid = 1'b0; eng_out_ready = 1'b0;
    eng_cnt = 0; force_err = 1'b0;
    set_phase('0, 0, 0, 0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    set_phase(4'hF, 100, 100, 100);   run_cycles(40);   // all requesters, full rate
    set_phase(4'b0100, 100, 100, 100); run_cycles(24);  // single requester
    set_phase(4'hF, 60, 50, 70);      run_cycles(300);  // random stalls
    set_phase(4'hF, 100, 100, 0);     run_cycles(20);   // tag FIFO fills
    set_phase(4'hF, 100, 100, 100);   run_cycles(10);
    set_phase(4'hF, 50, 80, 60);      run_cycles(100);
    do_reset();                                          // reset with tags queued
    run_cycles(100);

    set_phase('0, 0, 100, 100);       run_cycles(40);   // drain
    chk("drain_stage", DW'(exp_eng.size()), '0);
    chk("drain_tags", DW'(exp_tag.size()), '0);
    chk("drain_req_valid", DW'(req_valid), '0);

    do_reset();                                          // engine output with no tags
    force_err = 1'b1;
    eng_out_valid = 1'b1;
    eng_out_ready = 1'b1;
    run_cycles(3);
    force_err = 1'b0;
    run_cycles(10);
    chk("tag_error_sticky", DW'(tag_error), DW'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
